// File: rtl/conv_pkg.sv
// Shared definitions for the conv2d pass scheduler.
//   state_t         : scheduler FSM states
//   KERNEL_TAPS     : kernel words loaded per pass (3x3)
//   ENG_RST_CYCLES  : cycles the engine is held in reset before each pass
//   clogb2()        : ceil(log2(value)), never less than 1, so that
//                     single-entry indices still get a legal width
package conv_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ENG_RST,
        LOAD_K,
        WAIT_K,
        STREAM,
        FLUSH,
        DRAIN,
        NEXT,
        DONE
    } state_t;

    localparam int KERNEL_TAPS    = 9;
    localparam int ENG_RST_CYCLES = 2;

    function automatic int clogb2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_read_aligner.sv
// Pairs a synchronous-memory read strobe with the data it returns.
// The strobe is delayed one cycle so that valid and data line up.
// A fill request travels the same delay but produces a zero word with
// no memory access, which lets the feature path append padding beats
// directly behind the last real read without a gap or overlap.
//   clk, resetn : clock, asynchronous active-low reset
//   rd_en       : memory read strobe issued this cycle
//   fill        : request a zero beat this cycle (no memory read)
//   rdata       : memory read data, valid one cycle after rd_en
//   valid       : beat strobe, one cycle after rd_en or fill
//   data        : rdata for read beats, zero otherwise
module mem_read_aligner #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rd_en,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    logic rd_q;
    logic fill_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_q   <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            rd_q   <= rd_en;
            fill_q <= fill;
        end
    end

    assign valid = rd_q | fill_q;
    assign data  = rd_q ? rdata : '0;

endmodule

// File: rtl/conv2d_pass_scheduler.sv
// Walks the 3x3 convolution engine through every (filter, channel) pass
// of one layer: engine reset, kernel load, feature stream, flush tail,
// then waits for the engine to return a full map of results.
//   clk, resetn        : clock, asynchronous active-low reset
//   start / busy / done: layer handshake with the layer controller
//   w_rd_en/w_addr/w_rdata : weight memory read port (1-cycle latency)
//   f_rd_en/f_addr/f_rdata : feature memory read port (1-cycle latency)
//   conv_resetn        : engine reset (low during reset and ENG_RST)
//   load_kernel/kernel/load_kernel_done : engine kernel load interface
//   data_valid_in/data_in : engine pixel stream
//   valid_out_pixel    : engine result strobe
//   out_valid/out_filt/out_ch/out_pix/out_last_ch : result tags for the
//                        downstream channel accumulator
module conv2d_pass_scheduler
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 32,
    parameter int NUM_CH     = 3,
    parameter int NUM_FILT   = 8,
    parameter int ADDR_W     = 16
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                w_rd_en,
    output logic [ADDR_W-1:0]                   w_addr,
    input  logic [DATA_WIDTH-1:0]               w_rdata,
    output logic                                f_rd_en,
    output logic [ADDR_W-1:0]                   f_addr,
    input  logic [DATA_WIDTH-1:0]               f_rdata,
    output logic                                conv_resetn,
    output logic                                load_kernel,
    output logic [DATA_WIDTH-1:0]               kernel,
    input  logic                                load_kernel_done,
    output logic                                data_valid_in,
    output logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                valid_out_pixel,
    output logic                                out_valid,
    output logic [clogb2(NUM_FILT)-1:0]         out_filt,
    output logic [clogb2(NUM_CH)-1:0]           out_ch,
    output logic [clogb2(WIDTH*HEIGHT)-1:0]     out_pix,
    output logic                                out_last_ch
);

    localparam int WH     = WIDTH * HEIGHT;
    localparam int FILT_W = clogb2(NUM_FILT);
    localparam int CH_W   = clogb2(NUM_CH);
    localparam int PIX_W  = clogb2(WH);
    localparam int RES_W  = clogb2(WH + 1);
    // One sequencing counter is shared by every timed state.
    localparam int CNT_W  = clogb2(WH + WIDTH + KERNEL_TAPS + ENG_RST_CYCLES);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [FILT_W-1:0]  filt, filt_nxt;
    logic [CH_W-1:0]    ch, ch_nxt;
    logic [RES_W-1:0]   res_cnt;
    logic               fill;
    logic               counting;

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        filt_nxt  = filt;
        ch_nxt    = ch;
        w_rd_en   = 1'b0;
        f_rd_en   = 1'b0;
        fill      = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    state_nxt = ENG_RST;
                    filt_nxt  = '0;
                    ch_nxt    = '0;
                end
            end
            ENG_RST: begin
                if (cnt == CNT_W'(ENG_RST_CYCLES - 1)) begin
                    state_nxt = LOAD_K;
                    cnt_nxt   = '0;
                end
            end
            LOAD_K: begin
                w_rd_en = 1'b1;
                if (cnt == CNT_W'(KERNEL_TAPS - 1)) begin
                    state_nxt = WAIT_K;
                    cnt_nxt   = '0;
                end
            end
            WAIT_K: begin
                cnt_nxt = '0;
                if (load_kernel_done) state_nxt = STREAM;
            end
            STREAM: begin
                f_rd_en = 1'b1;
                if (cnt == CNT_W'(WH - 1)) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = '0;
                end
            end
            FLUSH: begin
                // WIDTH+1 zero beats push the last row out of the line buffers.
                fill = 1'b1;
                if (cnt == CNT_W'(WIDTH)) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                cnt_nxt = '0;
                if (res_cnt == RES_W'(WH)) state_nxt = NEXT;
            end
            NEXT: begin
                cnt_nxt   = '0;
                state_nxt = ENG_RST;
                if (ch != CH_W'(NUM_CH - 1)) begin
                    ch_nxt = ch + CH_W'(1);
                end else begin
                    ch_nxt = '0;
                    if (filt != FILT_W'(NUM_FILT - 1)) filt_nxt = filt + FILT_W'(1);
                    else                               state_nxt = DONE;
                end
            end
            DONE: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            filt    <= '0;
            ch      <= '0;
            res_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            filt  <= filt_nxt;
            ch    <= ch_nxt;
            if (state == ENG_RST)  res_cnt <= '0;
            else if (out_valid)    res_cnt <= res_cnt + RES_W'(1);
        end
    end

    assign w_addr = w_rd_en
        ? ADDR_W'((32'(filt) * 32'(NUM_CH) + 32'(ch)) * 32'(KERNEL_TAPS) + 32'(cnt))
        : '0;
    assign f_addr = f_rd_en ? ADDR_W'(32'(ch) * 32'(WH) + 32'(cnt)) : '0;

    // Index 0 aligns the weight path, index 1 the feature path.
    logic [1:0]                 aln_rd, aln_fill, aln_valid;
    logic [1:0][DATA_WIDTH-1:0] aln_rdata, aln_data;

    assign aln_rd    = {f_rd_en, w_rd_en};
    assign aln_fill  = {fill, 1'b0};
    assign aln_rdata = {f_rdata, w_rdata};

    for (genvar i = 0; i < 2; i++) begin : g_align
        mem_read_aligner #(.DATA_WIDTH(DATA_WIDTH)) u_align (
            .clk    (clk),
            .resetn (resetn),
            .rd_en  (aln_rd[i]),
            .fill   (aln_fill[i]),
            .rdata  (aln_rdata[i]),
            .valid  (aln_valid[i]),
            .data   (aln_data[i])
        );
    end

    assign load_kernel   = aln_valid[0];
    assign kernel        = aln_data[0];
    assign data_valid_in = aln_valid[1];
    assign data_in       = aln_data[1];

    // The engine's own kernel counter and done flag only clear on reset,
    // so it is pulsed at the head of every pass.
    assign conv_resetn = resetn & (state != ENG_RST);

    // Results can start arriving while the map is still streaming, so the
    // window opens at STREAM; anything past a full map is dropped.
    assign counting    = (state == STREAM) || (state == FLUSH) || (state == DRAIN);
    assign out_valid   = valid_out_pixel && counting && (res_cnt < RES_W'(WH));
    assign out_filt    = filt;
    assign out_ch      = ch;
    assign out_pix     = res_cnt[PIX_W-1:0];
    assign out_last_ch = (ch == CH_W'(NUM_CH - 1));

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    a_extra_result: assert property (@(posedge clk) disable iff (!resetn)
        (counting && valid_out_pixel) |-> (res_cnt < RES_W'(WH)));

endmodule

// File: tb/tb_conv2d_pass_scheduler.sv
// Scoreboard bench for conv2d_pass_scheduler with a small layer
// (4x4 map, 2 channels, 2 filters), behavioural memories and a
// behavioural 3x3 engine that returns one result per map pixel once
// WIDTH+1 beats have passed its line buffers.
module tb_conv2d_pass_scheduler;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NC = 2;
    localparam int NF = 2;
    localparam int AW = 16;
    localparam int WH = W * H;
    localparam logic [63:0] SENT = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, w_rd_en, f_rd_en, conv_resetn;
    logic          load_kernel, data_valid_in, out_valid, out_last_ch;
    logic [AW-1:0] w_addr, f_addr;
    logic [DW-1:0] w_rdata = '0;
    logic [DW-1:0] f_rdata = '0;
    logic [DW-1:0] kernel, data_in;
    logic          load_kernel_done = 1'b0;
    logic          valid_out_pixel = 1'b0;
    logic [0:0]    out_filt, out_ch;
    logic [3:0]    out_pix;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int n_rstwin = 0;
    int lowrun = 0;
    int kcnt = 0;
    int bcnt = 0;

    logic [63:0] w_q[$], k_q[$], f_q[$], d_q[$], o_q[$];

    conv2d_pass_scheduler #(
        .DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H),
        .NUM_CH(NC), .NUM_FILT(NF), .ADDR_W(AW)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .f_rd_en(f_rd_en), .f_addr(f_addr), .f_rdata(f_rdata),
        .conv_resetn(conv_resetn), .load_kernel(load_kernel), .kernel(kernel),
        .load_kernel_done(load_kernel_done), .data_valid_in(data_valid_in),
        .data_in(data_in), .valid_out_pixel(valid_out_pixel),
        .out_valid(out_valid), .out_filt(out_filt), .out_ch(out_ch),
        .out_pix(out_pix), .out_last_ch(out_last_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memories: data word = address + offset, one cycle after the strobe.
    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= 32'(w_addr) + 32'd100;
        if (f_rd_en) f_rdata <= 32'(f_addr) + 32'd1000;
    end

    // Engine model: sticky kernel-loaded flag after 9 loads; result for
    // beat index i >= W+1, one cycle after that beat.
    always @(posedge clk or negedge conv_resetn) begin
        if (!conv_resetn) begin
            kcnt             <= 0;
            load_kernel_done <= 1'b0;
            bcnt             <= 0;
            valid_out_pixel  <= 1'b0;
        end else begin
            if (load_kernel) begin
                kcnt <= kcnt + 1;
                if (kcnt == 8) load_kernel_done <= 1'b1;
            end
            valid_out_pixel <= data_valid_in && (bcnt >= W + 1);
            if (data_valid_in) bcnt <= bcnt + 1;
        end
    end

    // Monitor: pop and compare every strobe against the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!resetn) begin
            lowrun = 0;
        end else begin
            if (w_rd_en) begin
                e = SENT; if (w_q.size() > 0) e = w_q.pop_front();
                chk("w_addr", 64'(w_addr), e);
            end
            if (load_kernel) begin
                e = SENT; if (k_q.size() > 0) e = k_q.pop_front();
                chk("kernel", 64'(kernel), e);
            end
            if (f_rd_en) begin
                e = SENT; if (f_q.size() > 0) e = f_q.pop_front();
                chk("f_addr", 64'(f_addr), e);
            end
            if (data_valid_in) begin
                e = SENT; if (d_q.size() > 0) e = d_q.pop_front();
                chk("data_in", 64'(data_in), e);
                chk("kdone_before_stream", 64'(load_kernel_done), 64'(1));
            end
            if (out_valid) begin
                e = SENT; if (o_q.size() > 0) e = o_q.pop_front();
                chk("out_tag", 64'({out_filt, out_ch, out_pix, out_last_ch}), e);
            end
            if (!conv_resetn) begin
                lowrun++;
            end else if (lowrun > 0) begin
                chk("eng_rst_len", 64'(lowrun), 64'(2));
                chk("lk_after_rst", 64'(w_rd_en), 64'(1));
                chk("kdone_cleared", 64'(load_kernel_done), 64'(0));
                n_rstwin++;
                lowrun = 0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_layer();
        for (int f = 0; f < NF; f++) begin
            for (int c = 0; c < NC; c++) begin
                int p = f * NC + c;
                for (int k = 0; k < 9; k++) begin
                    w_q.push_back(64'(p * 9 + k));
                    k_q.push_back(64'(p * 9 + k + 100));
                end
                for (int px = 0; px < WH; px++) begin
                    f_q.push_back(64'(c * WH + px));
                    d_q.push_back(64'(c * WH + px + 1000));
                end
                for (int z = 0; z <= W; z++) d_q.push_back(64'(0));
                for (int px = 0; px < WH; px++)
                    o_q.push_back(64'({1'(f), 1'(c), 4'(px), (c == NC - 1)}));
            end
        end
    endtask

    task automatic check_quiet(input string pfx);
        chk({pfx, "_strobes"}, 64'({busy, done, w_rd_en, f_rd_en, load_kernel,
                                   data_valid_in, out_valid, out_last_ch, conv_resetn}), 64'(0));
        chk({pfx, "_w_addr"}, 64'(w_addr), 64'(0));
        chk({pfx, "_f_addr"}, 64'(f_addr), 64'(0));
        chk({pfx, "_kernel"}, 64'(kernel), 64'(0));
        chk({pfx, "_data_in"}, 64'(data_in), 64'(0));
        chk({pfx, "_tags"}, 64'({out_filt, out_ch, out_pix}), 64'(0));
    endtask

    task automatic start_layer();
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); chk("busy_before_accept", 64'(busy), 64'(0));
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_layer_end(input int exp_done);
        chk("w_q_left", 64'(w_q.size()), 64'(0));
        chk("k_q_left", 64'(k_q.size()), 64'(0));
        chk("f_q_left", 64'(f_q.size()), 64'(0));
        chk("d_q_left", 64'(d_q.size()), 64'(0));
        chk("o_q_left", 64'(o_q.size()), 64'(0));
        chk("eng_rst_windows", 64'(n_rstwin), 64'(4));
        chk("done_count", 64'(done_cnt), 64'(exp_done));
    endtask

    initial begin
        bit seen;

        // Reset state
        repeat (2) @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1 resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_conv_resetn", 64'(conv_resetn), 64'(1));

        // Layer 1: full run, stray start while busy and in DONE
        push_layer();
        n_rstwin = 0;
        start_layer();
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(seen);
        chk("done_seen_1", 64'(seen), 64'(1));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("outs_before_done", 64'(o_q.size()), 64'(0));
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("start_in_done_ignored", 64'({busy, w_rd_en, conv_resetn}), 64'(1));
        end
        check_layer_end(1);

        // Layer 2: reset in the middle of pass 2 streaming
        push_layer();
        start_layer();
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (f_rd_en && out_filt == 1'b0 && out_ch == 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("pass2_stream_seen", 64'(seen), 64'(1));
        resetn = 1'b0;
        #2;
        check_quiet("midrst");
        repeat (3) @(negedge clk);
        chk("no_done_on_reset", 64'(done_cnt), 64'(1));
        w_q.delete(); k_q.delete(); f_q.delete(); d_q.delete(); o_q.delete();
        @(posedge clk); #1 resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_midrst", 64'({busy, done}), 64'(0));

        // Layer 3: fresh start repeats the layer from pass 0
        n_rstwin = 0;
        push_layer();
        start_layer();
        wait_done(seen);
        chk("done_seen_3", 64'(seen), 64'(1));
        chk("busy_at_done_3", 64'(busy), 64'(0));
        @(negedge clk);
        check_layer_end(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
